// File: rtl/uart_coord_frame_ctrl.sv
// uart_coord_frame_ctrl
// Frame sequencer between the UART receive datapath and the video pointer
// logic. Hunts for a header byte, collects six tagged BCD digits (x then y,
// hundreds/tens/units), verifies an XOR checksum, range-checks the result and
// commits x_pos/y_pos atomically with a one-cycle pos_valid pulse. Also gates
// the receiver, supervises the inter-byte timeout and reports/counts errors.
module uart_coord_frame_ctrl #(
  parameter logic [7:0] HDR_BYTE    = 8'h55,
  parameter int         TIMEOUT_CYC = 5000,
  parameter int         X_MAX       = 639,
  parameter int         Y_MAX       = 479
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       rx_en,
  output logic       busy,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       pos_valid,
  output logic [1:0] err_code,
  output logic       err_pulse,
  output logic [7:0] err_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  // Timer value at which an idle frame is abandoned.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_FORMAT  = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    S_HUNT,
    S_DIG,
    S_CHK,
    S_COMMIT
  } state_t;

  state_t          r_state;
  logic [2:0]      r_idx;
  logic [7:0]      r_acc;
  logic [TW-1:0]   r_timer;
  logic [3:0]      r_dig [0:5];
  logic            r_rx_en;
  logic [9:0]      r_x_pos;
  logic [9:0]      r_y_pos;
  logic            r_pos_valid;
  logic [1:0]      r_err_code;
  logic            r_err_pulse;
  logic [7:0]      r_err_cnt;

  logic            w_dig_ok;
  logic [TW-1:0]   w_timer_inc;
  logic            w_expire;
  logic [9:0]      w_x;
  logic [9:0]      w_y;
  logic            w_in_range;
  logic            w_err;
  logic [1:0]      w_err_kind;

  // A digit byte carries its position (1..6) in the high nibble and BCD below.
  assign w_dig_ok    = (rx_data[7:4] == ({1'b0, r_idx} + 4'd1)) && (rx_data[3:0] <= 4'd9);
  // Expiry happens on the edge where the idle timer would reach its last value;
  // a byte arriving on that same edge wins.
  assign w_timer_inc = r_timer + TW'(1);
  assign w_expire    = !rx_done && (w_timer_inc == TMO_LAST);

  // Decimal reconstruction; 999 fits in 10 bits so no overflow handling.
  assign w_x = 10'(r_dig[0]) * 10'd100 + 10'(r_dig[1]) * 10'd10 + 10'(r_dig[2]);
  assign w_y = 10'(r_dig[3]) * 10'd100 + 10'(r_dig[4]) * 10'd10 + 10'(r_dig[5]);
  assign w_in_range = (w_x <= 10'(X_MAX)) && (w_y <= 10'(Y_MAX));

  // Classify the error (if any) raised on the coming edge.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_err      = 1'b0;
    w_err_kind = 2'd0;
    if (enable) begin
      case (r_state)
        S_DIG: begin
          if (rx_done && !w_dig_ok) begin
            w_err      = 1'b1;
            w_err_kind = ERR_FORMAT;
          end else if (w_expire) begin
            w_err      = 1'b1;
            w_err_kind = ERR_TIMEOUT;
          end
        end
        S_CHK: begin
          if (rx_done && (rx_data != r_acc)) begin
            w_err      = 1'b1;
            w_err_kind = ERR_FORMAT;
          end else if (w_expire) begin
            w_err      = 1'b1;
            w_err_kind = ERR_TIMEOUT;
          end
        end
        S_COMMIT: begin
          if (!w_in_range) begin
            w_err      = 1'b1;
            w_err_kind = ERR_RANGE;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame sequencer: header hunt, digit collection, checksum and commit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_HUNT;
      r_idx       <= 3'd0;
      r_acc       <= 8'd0;
      r_timer     <= '0;
      r_rx_en     <= 1'b0;
      r_x_pos     <= 10'd0;
      r_y_pos     <= 10'd0;
      r_pos_valid <= 1'b0;
      // NOTE: the digit store is six flops, not a RAM, so it is cleared with
      // everything else and a commit can never see stale power-up values.
      for (int i = 0; i < 6; i++) r_dig[i] <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments throughout so every branch reads the
      // pre-edge state regardless of statement order.
      r_rx_en     <= enable;
      r_pos_valid <= 1'b0;
      if (!enable) begin
        r_state <= S_HUNT;
        r_timer <= '0;
      end else begin
        case (r_state)
          S_HUNT: begin
            if (rx_done && (rx_data == HDR_BYTE)) begin
              r_state <= S_DIG;
              r_idx   <= 3'd0;
              r_acc   <= HDR_BYTE;
              r_timer <= '0;
            end
          end
          S_DIG: begin
            if (rx_done) begin
              r_timer <= '0;
              if (w_dig_ok) begin
                r_dig[r_idx] <= rx_data[3:0];
                r_acc        <= r_acc ^ rx_data;
                if (r_idx == 3'd5) begin
                  r_state <= S_CHK;
                  r_idx   <= 3'd0;
                end else begin
                  r_idx <= r_idx + 3'd1;
                end
              end else if (rx_data == HDR_BYTE) begin
                r_idx <= 3'd0;
                r_acc <= HDR_BYTE;
              end else begin
                r_state <= S_HUNT;
              end
            end else if (w_expire) begin
              r_state <= S_HUNT;
              r_timer <= '0;
            end else begin
              r_timer <= w_timer_inc;
            end
          end
          S_CHK: begin
            if (rx_done) begin
              r_timer <= '0;
              r_state <= (rx_data == r_acc) ? S_COMMIT : S_HUNT;
            end else if (w_expire) begin
              r_state <= S_HUNT;
              r_timer <= '0;
            end else begin
              r_timer <= w_timer_inc;
            end
          end
          S_COMMIT: begin
            if (w_in_range) begin
              r_x_pos     <= w_x;
              r_y_pos     <= w_y;
              r_pos_valid <= 1'b1;
            end
            r_state <= S_HUNT;
          end
          default: r_state <= S_HUNT;
        endcase
      end
    end
  end

  // Error reporting: sticky code, one-cycle pulse, saturating count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err_code  <= 2'd0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= 8'd0;
    end else begin
      r_err_pulse <= w_err;
      if (w_err) begin
        r_err_code <= w_err_kind;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign rx_en     = r_rx_en;
  assign busy      = (r_state != S_HUNT);
  assign x_pos     = r_x_pos;
  assign y_pos     = r_y_pos;
  assign pos_valid = r_pos_valid;
  assign err_code  = r_err_code;
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_uart_coord_frame_ctrl.sv
// Self-checking bench for uart_coord_frame_ctrl. A frame-level reference model
// (queue of collected digits, XOR reduction, decimal arithmetic) predicts every
// output on every clock; directed frames cover the listed scenarios and a
// randomized section mixes clean and damaged frames.
module tb_uart_coord_frame_ctrl;

  localparam logic [7:0] HDR = 8'h55;
  localparam int T  = 20;
  localparam int XM = 639;
  localparam int YM = 479;

  logic       CLK = 1'b0;
  logic       RST;
  logic       enable;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       rx_en;
  logic       busy;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic       pos_valid;
  logic [1:0] err_code;
  logic       err_pulse;
  logic [7:0] err_cnt;

  uart_coord_frame_ctrl #(
    .HDR_BYTE   (HDR),
    .TIMEOUT_CYC(T),
    .X_MAX      (XM),
    .Y_MAX      (YM)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .enable   (enable),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .rx_en    (rx_en),
    .busy     (busy),
    .x_pos    (x_pos),
    .y_pos    (y_pos),
    .pos_valid(pos_valid),
    .err_code (err_code),
    .err_pulse(err_pulse),
    .err_cnt  (err_cnt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 hunting, 1 collecting digits, 2 awaiting checksum, 3 commit cycle
  int         m_phase;
  logic [7:0] m_digs[$];
  int         m_idle;
  int         e_x, e_y, e_code, e_cnt;
  bit         e_pv, e_ep, e_rxen;

  task automatic model_reset();
    m_phase = 0;
    m_digs.delete();
    m_idle = 0;
    e_x = 0; e_y = 0; e_code = 0; e_cnt = 0;
    e_pv = 0; e_ep = 0; e_rxen = 0;
  endtask

  task automatic model_err(input int code);
    e_code = code;
    e_ep   = 1;
    if (e_cnt < 255) e_cnt++;
  endtask

  function automatic int dval(input int i);
    return int'(m_digs[i] & 8'h0F);
  endfunction

  function automatic logic [7:0] frame_chk();
    logic [7:0] c = HDR;
    foreach (m_digs[i]) c = c ^ m_digs[i];
    return c;
  endfunction

  task automatic idle_step();
    m_idle++;
    if (m_idle == T - 1) begin
      model_err(3);
      m_phase = 0;
    end
  endtask

  // Apply one clock edge with the given inputs to the model.
  task automatic model_edge(input bit en, input bit done, input logic [7:0] d);
    int x, y;
    e_pv = 0;
    e_ep = 0;
    e_rxen = en;
    if (!en) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (done && d == HDR) begin
             m_phase = 1;
             m_digs.delete();
             m_idle = 0;
           end
        1: if (done) begin
             m_idle = 0;
             if (int'(d[7:4]) == m_digs.size() + 1 && d[3:0] <= 4'd9) begin
               m_digs.push_back(d);
               if (m_digs.size() == 6) m_phase = 2;
             end else if (d == HDR) begin
               m_digs.delete();
               model_err(1);
             end else begin
               model_err(1);
               m_phase = 0;
             end
           end else idle_step();
        2: if (done) begin
             m_idle = 0;
             if (d == frame_chk()) m_phase = 3;
             else begin
               model_err(1);
               m_phase = 0;
             end
           end else idle_step();
        default: begin
          x = 100 * dval(0) + 10 * dval(1) + dval(2);
          y = 100 * dval(3) + 10 * dval(4) + dval(5);
          if (x <= XM && y <= YM) begin
            e_x = x;
            e_y = y;
            e_pv = 1;
          end else model_err(2);
          m_phase = 0;
        end
      endcase
    end
  endtask

  task automatic check_all();
    check("rx_en",     rx_en,     e_rxen);
    check("busy",      busy,      (m_phase != 0));
    check("x_pos",     x_pos,     e_x);
    check("y_pos",     y_pos,     e_y);
    check("pos_valid", pos_valid, e_pv);
    check("err_code",  err_code,  e_code);
    check("err_pulse", err_pulse, e_ep);
    check("err_cnt",   err_cnt,   e_cnt);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick(input bit en, input bit done, input logic [7:0] d);
    enable  = en;
    rx_done = done;
    rx_data = d;
    @(posedge CLK);
    model_edge(en, done, d);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    idle(gap);
    tick(1'b1, 1'b1, b);
  endtask

  task automatic send_q(input logic [7:0] q[$], input int gap);
    foreach (q[i]) send_byte(q[i], gap);
  endtask

  function automatic void build_frame(input int x, input int y, output logic [7:0] q[$]);
    int d[6];
    logic [7:0] c;
    d[0] = x / 100; d[1] = (x / 10) % 10; d[2] = x % 10;
    d[3] = y / 100; d[4] = (y / 10) % 10; d[5] = y % 10;
    q.delete();
    q.push_back(HDR);
    c = HDR;
    for (int i = 0; i < 6; i++) begin
      q.push_back(8'((i + 1) * 16 + d[i]));
      c = c ^ q[i + 1];
    end
    q.push_back(c);
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] f[$];
    logic [7:0] g[$];
    int cnt0;

    RST = 1'b1; enable = 1'b0; rx_done = 1'b0; rx_data = 8'd0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_all();
    RST = 1'b0;
    idle(2);

    // Spec frame: x=320, y=240
    f = '{8'h55, 8'h13, 8'h22, 8'h30, 8'h42, 8'h54, 8'h60, 8'h22};
    send_q(f, 1);
    idle(2);
    check("t1_x", x_pos, 320);
    check("t1_y", y_pos, 240);
    check("t1_cnt", err_cnt, 0);

    // Bad checksum
    f[7] = 8'h23;
    send_q(f, 1);
    idle(2);
    check("t2_code", err_code, 1);
    check("t2_cnt", err_cnt, 1);
    check("t2_busy", busy, 0);
    check("t2_x_kept", x_pos, 320);
    build_frame(123, 456, g);
    send_q(g, 2);
    idle(2);
    check("t2_x_next", x_pos, 123);
    check("t2_y_next", y_pos, 456);

    // Out of range y
    build_frame(639, 482, g);
    send_q(g, 1);
    idle(2);
    check("t3_code", err_code, 2);
    check("t3_x_kept", x_pos, 123);
    check("t3_y_kept", y_pos, 456);

    // Timeout after header + 3 digits
    f = '{8'h55, 8'h11, 8'h22, 8'h33};
    send_q(f, 1);
    idle(T + 2);
    check("t4_code", err_code, 3);
    check("t4_busy", busy, 0);
    // Byte arriving exactly on the expiry edge is accepted
    cnt0 = e_cnt;
    build_frame(123, 457, g);
    for (int i = 0; i < 8; i++) send_byte(g[i], (i == 4) ? T - 2 : 1);
    idle(2);
    check("t4b_cnt", err_cnt, cnt0);
    check("t4b_y", y_pos, 457);

    // Resync on header inside digits
    cnt0 = e_cnt;
    f = '{8'h55, 8'h13, 8'h55};
    send_q(f, 1);
    build_frame(320, 240, g);
    for (int i = 1; i < 8; i++) send_byte(g[i], 1);
    idle(2);
    check("t5_cnt", err_cnt, cnt0 + 1);
    check("t5_code", err_code, 1);
    check("t5_x", x_pos, 320);

    // Enable dropped mid-frame
    cnt0 = e_cnt;
    f = '{8'h55, 8'h13, 8'h22};
    send_q(f, 1);
    tick(1'b0, 1'b0, 8'h00);
    check("t6_rx_en", rx_en, 0);
    check("t6_busy", busy, 0);
    check("t6_cnt", err_cnt, cnt0);
    idle(2);

    // Byte delivered during the commit cycle is ignored
    build_frame(100, 200, g);
    send_q(g, 1);
    tick(1'b1, 1'b1, HDR);
    idle(1);
    check("t7_busy", busy, 0);
    check("t7_x", x_pos, 100);

    // Randomized frames with occasional damage
    for (int n = 0; n < 150; n++) begin
      int mut, pos, gsel;
      build_frame($urandom_range(0, 720), $urandom_range(0, 520), g);
      mut = $urandom_range(0, 9);
      pos = $urandom_range(1, 7);
      gsel = $urandom_range(0, 2);
      case (mut)
        0: g[7] = g[7] ^ (8'd1 << $urandom_range(0, 7));
        1: g[pos] = 8'($urandom);
        2: g.insert(pos, HDR);
        default: ;
      endcase
      foreach (g[i]) begin
        int gap;
        gap = $urandom_range(1, 3);
        if (mut == 3 && i == pos) gap = (gsel == 0) ? T - 2 : ((gsel == 1) ? T - 1 : T + 3);
        if (mut == 4 && i == pos) tick(1'b0, 1'b0, 8'($urandom));
        send_byte(g[i], gap);
      end
      idle(2);
    end

    // Error counter saturation
    f = '{8'h55, 8'h13, 8'h22, 8'h30, 8'h42, 8'h54, 8'h60, 8'h23};
    for (int n = 0; n < 260; n++) send_q(f, 1);
    idle(2);
    check("t9_sat", err_cnt, 255);

    // Asynchronous reset mid-frame
    build_frame(321, 241, g);
    send_q(g, 1);
    idle(2);
    f = '{8'h55, 8'h13};
    send_q(f, 1);
    rx_done = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    check("t10_x", x_pos, 0);
    check("t10_y", y_pos, 0);
    check("t10_busy", busy, 0);
    check("t10_cnt", err_cnt, 0);
    check("t10_code", err_code, 0);
    check("t10_rx_en", rx_en, 0);
    model_reset();
    @(posedge CLK);
    #1;
    check_all();
    RST = 1'b0;
    build_frame(5, 7, g);
    send_q(g, 1);
    idle(2);
    check("t10_recover_x", x_pos, 5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
